// File: rtl/datapath_pkg.sv
// Shared definitions for the neuron datapath and its router.
// Holds the instruction layout, opcode values, datapath state encoding,
// multiplier iteration count and the saturating MAC accumulate helper.
package datapath_pkg;

    localparam int INSTRUCTION_WIDTH = 36;
    localparam int RESULT_WIDTH      = 32;
    localparam int OPERAND_WIDTH     = 16;
    localparam int MUL_CYCLES        = 16;

    // Instruction word layout: opcode[35:32], a[31:16], b[15:0]
    localparam int OPCODE_MSB = 35;
    localparam int OPCODE_LSB = 32;
    localparam int A_MSB      = 31;
    localparam int A_LSB      = 16;
    localparam int B_MSB      = 15;
    localparam int B_LSB      = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_CLR  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_MAC  = 4'd3;
    localparam logic [3:0] OP_RELU = 4'd4;
    localparam logic [3:0] OP_READ = 4'd5;

    // Returned for every opcode outside the defined set
    localparam logic [31:0] RESULT_ILLEGAL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_ACC  = 2'd3
    } dp_state_e;

    // acc (Q24.8) + (signed Q16.16 product >>> 8), summed at 33 bits and
    // clamped to the 32-bit signed range on overflow.
    function automatic logic [31:0] mac_accumulate(
        input logic [31:0] acc,
        input logic [31:0] product_mag,
        input logic        negative
    );
        logic signed [31:0] product_signed;
        logic signed [31:0] product_scaled;
        logic        [32:0] sum;
        logic        [31:0] result;
        product_signed = negative ? $signed(32'(-product_mag)) : $signed(product_mag);
        product_scaled = product_signed >>> 8;
        sum = {acc[31], acc} + {product_scaled[31], product_scaled};
        // The two top bits disagree only when the signed add left the 32-bit range
        if (sum[32] != sum[31]) begin
            result = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            result = sum[31:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// 16x16 unsigned shift-add multiplier.
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   start          - loads operands and begins a new multiplication
//   multiplicand   - unsigned 16-bit operand
//   multiplier     - unsigned 16-bit operand
//   product        - 32-bit unsigned product, final after the last iteration
//   done           - high during the cycle whose closing edge performs the
//                    final (16th) iteration, so the consumer can advance on
//                    the same edge the product becomes final
module seq_multiplier (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic [31:0] product,
    output logic        done
);
    import datapath_pkg::*;

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [31:0]      mcand_reg;
    logic [31:0]      product_reg;
    logic [15:0]      mplier_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_reg   <= '0;
            product_reg <= '0;
            mplier_reg  <= '0;
            count_reg   <= '0;
        end else if (start) begin
            mcand_reg   <= {16'd0, multiplicand};
            mplier_reg  <= multiplier;
            product_reg <= '0;
            count_reg   <= CNT_W'(MUL_CYCLES);
        end else if (count_reg != '0) begin
            // One multiplier bit per cycle, LSB first, with a left-shifting multiplicand
            if (mplier_reg[0]) begin
                product_reg <= product_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CNT_W'(1);
        end
    end

    assign product = product_reg;
    assign done    = (count_reg == CNT_W'(1));

endmodule

// File: rtl/neuron_datapath.sv
// Neuron datapath: executes one instruction per accepted start request,
// holding a signed Q24.8 accumulator. MAC uses a sequential multiplier.
// Ports:
//   clock          - sole clock, rising edge
//   reset          - asynchronous active-high reset
//   instruction_dp - opcode[35:32], a[31:16], b[15:0]; sampled on accept
//   start_dp       - request; only a rising edge seen while idle is accepted
//   result_dp      - result of the last completed instruction
//   finished_dp    - high when idle and result_dp is valid
module neuron_datapath #(
    parameter int INSTRUCTION_WIDTH = datapath_pkg::INSTRUCTION_WIDTH,
    parameter int RESULT_WIDTH      = datapath_pkg::RESULT_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
    input  logic                         start_dp,
    output logic [RESULT_WIDTH-1:0]      result_dp,
    output logic                         finished_dp
);
    import datapath_pkg::*;

    dp_state_e                state_reg, state_next;
    logic [3:0]               opcode_reg;
    logic [RESULT_WIDTH-1:0]  ab_reg;
    logic                     negative_reg;
    logic [RESULT_WIDTH-1:0]  acc_reg;
    logic [RESULT_WIDTH-1:0]  result_reg;
    logic                     finished_reg;
    logic                     start_prev_reg;
    logic                     armed_reg;

    logic [3:0]               opcode_in;
    logic [15:0]              a_in, b_in;
    logic [15:0]              a_mag, b_mag;
    logic                     accept;
    logic                     mul_start;
    logic                     mul_done;
    logic [31:0]              mul_product;
    logic [RESULT_WIDTH-1:0]  exec_result;
    logic [RESULT_WIDTH-1:0]  exec_acc;
    logic [RESULT_WIDTH-1:0]  mac_acc;

    assign opcode_in = instruction_dp[OPCODE_MSB:OPCODE_LSB];
    assign a_in      = instruction_dp[A_MSB:A_LSB];
    assign b_in      = instruction_dp[B_MSB:B_LSB];

    // Two's-complement magnitude; 0x8000 maps to 0x8000, which is exact as unsigned
    assign a_mag = a_in[15] ? 16'(~a_in + 16'd1) : a_in;
    assign b_mag = b_in[15] ? 16'(~b_in + 16'd1) : b_in;

    // armed_reg blocks the first edge after reset, so a start already high
    // when reset releases is not mistaken for a fresh request.
    assign accept    = armed_reg && start_dp && !start_prev_reg && (state_reg == ST_IDLE);
    assign mul_start = accept && (opcode_in == OP_MAC);

    seq_multiplier u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (a_mag),
        .multiplier   (b_mag),
        .product      (mul_product),
        .done         (mul_done)
    );

    assign mac_acc = mac_accumulate(acc_reg, mul_product, negative_reg);

    always_comb begin
        exec_result = RESULT_ILLEGAL;
        exec_acc    = acc_reg;
        case (opcode_reg)
            OP_NOP:  exec_result = '0;
            OP_CLR: begin
                exec_acc    = '0;
                exec_result = '0;
            end
            OP_LOAD: begin
                exec_acc    = ab_reg;
                exec_result = ab_reg;
            end
            OP_RELU: exec_result = acc_reg[RESULT_WIDTH-1] ? '0 : acc_reg;
            OP_READ: exec_result = acc_reg;
            default: exec_result = RESULT_ILLEGAL;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (opcode_in == OP_MAC) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_IDLE;
            ST_MUL:  if (mul_done) state_next = ST_ACC;
            ST_ACC:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            opcode_reg     <= OP_NOP;
            ab_reg         <= '0;
            negative_reg   <= 1'b0;
            acc_reg        <= '0;
            result_reg     <= '0;
            finished_reg   <= 1'b1;
            start_prev_reg <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= start_dp;
            armed_reg      <= 1'b1;
            if (accept) begin
                opcode_reg   <= opcode_in;
                ab_reg       <= {a_in, b_in};
                negative_reg <= a_in[15] ^ b_in[15];
                finished_reg <= 1'b0;
            end
            case (state_reg)
                ST_EXEC: begin
                    acc_reg      <= exec_acc;
                    result_reg   <= exec_result;
                    finished_reg <= 1'b1;
                end
                ST_ACC: begin
                    acc_reg      <= mac_acc;
                    result_reg   <= mac_acc;
                    finished_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result_dp   = result_reg;
    assign finished_dp = finished_reg;

endmodule

// File: tb/tb_neuron_datapath.sv
// Directed testbench for neuron_datapath with hand-computed expected values.
module tb_neuron_datapath;
    import datapath_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [35:0] instruction_dp;
    logic        start_dp;
    logic [31:0] result_dp;
    logic        finished_dp;

    int n_checks = 0;
    int n_errors = 0;
    int low_cnt;

    always #5 clock = ~clock;

    neuron_datapath dut (
        .clock          (clock),
        .reset          (reset),
        .instruction_dp (instruction_dp),
        .start_dp       (start_dp),
        .result_dp      (result_dp),
        .finished_dp    (finished_dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one instruction as a single-cycle start pulse, counts the
    // sampled cycles with finished_dp low, then checks result and latency.
    task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp, input int exp_low);
        int low;
        @(negedge clock);
        instruction_dp = {op, a, b};
        start_dp = 1'b1;
        @(negedge clock);
        start_dp = 1'b0;
        low = 0;
        while (!finished_dp && low < 40) begin
            low++;
            @(negedge clock);
        end
        $display("txn %-16s op=%h a=%h b=%h result=%h busy_cycles=%0d", tag, op, a, b, result_dp, low);
        check({tag, "_result"}, result_dp, exp);
        check({tag, "_latency"}, 32'(low), 32'(exp_low));
    endtask

    initial begin
        reset = 1'b1;
        start_dp = 1'b0;
        instruction_dp = '0;
        repeat (2) @(negedge clock);
        check("reset_result", result_dp, 32'h0);
        check("reset_finished", {31'd0, finished_dp}, 32'd1);

        // start already high when reset releases must not be accepted
        start_dp = 1'b1;
        instruction_dp = {OP_LOAD, 16'h5555, 16'h5555};
        @(negedge clock);
        reset = 1'b0;
        low_cnt = 0;
        repeat (4) begin
            @(negedge clock);
            if (!finished_dp) low_cnt++;
        end
        start_dp = 1'b0;
        check("start_high_at_release", 32'(low_cnt), 32'd0);

        run("read_after_reset", OP_READ, 16'h0000, 16'h0000, 32'h0000_0000, 1);

        run("clr_a",     OP_CLR,  16'h0000, 16'h0000, 32'h0000_0000, 1);
        run("mac_pos",   OP_MAC,  16'h0200, 16'h0180, 32'h0000_0300, 17);
        run("read_pos",  OP_READ, 16'h0000, 16'h0000, 32'h0000_0300, 1);

        run("clr_b",     OP_CLR,  16'h0000, 16'h0000, 32'h0000_0000, 1);
        run("mac_neg",   OP_MAC,  16'hFF00, 16'h0100, 32'hFFFF_FF00, 17);
        run("relu_neg",  OP_RELU, 16'h0000, 16'h0000, 32'h0000_0000, 1);
        run("read_neg",  OP_READ, 16'h0000, 16'h0000, 32'hFFFF_FF00, 1);

        run("load_hi",   OP_LOAD, 16'h7FFF, 16'hFF00, 32'h7FFF_FF00, 1);
        run("mac_satp",  OP_MAC,  16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF, 17);
        run("load_lo",   OP_LOAD, 16'h8000, 16'h0000, 32'h8000_0000, 1);
        run("mac_satn",  OP_MAC,  16'h8000, 16'h7FFF, 32'h8000_0000, 17);

        run("load_mix",  OP_LOAD, 16'h1234, 16'h5678, 32'h1234_5678, 1);
        run("nop",       OP_NOP,  16'hAAAA, 16'hBBBB, 32'h0000_0000, 1);
        run("relu_pos",  OP_RELU, 16'h0000, 16'h0000, 32'h1234_5678, 1);
        run("read_mix",  OP_READ, 16'h0000, 16'h0000, 32'h1234_5678, 1);

        // start held two cycles, then re-pulsed mid-multiply with new operands
        run("clr_c",     OP_CLR,  16'h0000, 16'h0000, 32'h0000_0000, 1);
        @(negedge clock);
        instruction_dp = {OP_MAC, 16'h0100, 16'h0100};
        start_dp = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (!finished_dp) low_cnt++;
            if (i == 1) start_dp = 1'b0;
            if (i == 7) begin
                start_dp = 1'b1;
                instruction_dp = {OP_MAC, 16'h7FFF, 16'h7FFF};
            end
            if (i == 8) start_dp = 1'b0;
        end
        $display("txn %-16s op=%h result=%h busy_cycles=%0d", "mac_restart", OP_MAC, result_dp, low_cnt);
        check("mac_restart_busy", 32'(low_cnt), 32'd17);
        check("mac_restart_result", result_dp, 32'h0000_0100);
        run("illegal_f", 4'hF,    16'h1111, 16'h2222, 32'hFFFF_FFFF, 1);
        run("read_once", OP_READ, 16'h0000, 16'h0000, 32'h0000_0100, 1);

        // reset in the middle of a multiply
        run("load_pre",  OP_LOAD, 16'h0000, 16'h1000, 32'h0000_1000, 1);
        @(negedge clock);
        instruction_dp = {OP_MAC, 16'h0100, 16'h0100};
        start_dp = 1'b1;
        @(negedge clock);
        start_dp = 1'b0;
        repeat (4) @(negedge clock);
        check("busy_before_reset", {31'd0, finished_dp}, 32'd0);
        #2 reset = 1'b1;
        #1;
        $display("txn %-16s result=%h finished=%0d", "reset_mid_mul", result_dp, finished_dp);
        check("reset_mid_finished", {31'd0, finished_dp}, 32'd1);
        check("reset_mid_result", result_dp, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run("read_post_rst", OP_READ, 16'h0000, 16'h0000, 32'h0000_0000, 1);
        run("load_post_rst", OP_LOAD, 16'h0000, 16'h0123, 32'h0000_0123, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
